// File: rtl/sram_arbiter.sv
// sram_arbiter: three-port arbiter for one asynchronous SRAM.
// Each port issues single-word reads or writes. The SRAM strobes are decoded
// from the access state machine. With the SRAM_ARB_RR_EN macro defined the
// arbiter is round-robin; without it, port 0 has the highest priority and
// port 2 the lowest.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [2:0]        wdone,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        owner,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_OE, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        wait_cnt;
  logic              pulse_cnt;
  logic [1:0]        owner_q;
  logic              win_vld;
  logic [1:0]        win_idx;
  logic              grant_fire;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  function automatic logic [2:0] port_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

`ifdef SRAM_ARB_RR_EN
  logic [1:0] rr_ptr;

  // Round-robin winner: first requesting port found searching up from the pointer
  always_comb begin
    int k;
    k       = 0;
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      k = (int'(rr_ptr) + i) % 3;
      if (!win_vld && req[k[1:0]]) begin
        win_vld = 1'b1;
        win_idx = k[1:0];
      end
    end
  end

  // Pointer moves to the port after the grantee so every holder is reached within two accesses
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 2'd0;
    end else if (grant_fire) begin
      rr_ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
  end
`else
  // Fixed-priority winner: lowest-numbered requesting port
  always_comb begin
    win_vld = |req;
    win_idx = 2'd0;
    if (req[0])      win_idx = 2'd0;
    else if (req[1]) win_idx = 2'd1;
    else if (req[2]) win_idx = 2'd2;
  end
`endif

  // Requests are only accepted between accesses and never while reset is held
  assign grant_fire = (state == IDLE) && win_vld && !RST;

  // Route the winning port's command fields to the capture registers
  always_comb begin
    we_sel    = we[0];
    addr_sel  = addr0;
    wdata_sel = wdata0;
    unique case (win_idx)
      2'd1: begin
        we_sel    = we[1];
        addr_sel  = addr1;
        wdata_sel = wdata1;
      end
      2'd2: begin
        we_sel    = we[2];
        addr_sel  = addr2;
        wdata_sel = wdata2;
      end
      default: ;
    endcase
  end

  // Access state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus SRAM strobes and handshake pulses decoded from the state
  always_comb begin
    state_nxt  = state;
    gnt        = 3'b000;
    wdone      = 3'b000;
    busy       = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_fire) begin
          gnt       = port_onehot(win_idx);
          state_nxt = we_sel ? WR_SETUP : RD_ADDR;
        end
      end
      RD_ADDR: state_nxt = RD_OE;
      RD_OE: begin
        sram_oe_n = 1'b0;
        if (wait_cnt == WAIT_LAST) state_nxt = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        sram_oe_n = 1'b0;
        state_nxt = IDLE;
      end
      WR_SETUP: begin
        sram_dq_oe = 1'b1;
        state_nxt  = WR_PULSE;
      end
      WR_PULSE: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
        if (pulse_cnt) state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        sram_dq_oe = 1'b1;
        wdone      = port_onehot(owner_q);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counters, current owner and the read-complete pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt  <= 3'd0;
      pulse_cnt <= 1'b0;
      owner_q   <= 2'd0;
      rvalid    <= 3'b000;
    end else begin
      wait_cnt  <= (state == RD_OE) ? wait_cnt + 3'd1 : 3'd0;
      pulse_cnt <= (state == WR_PULSE) ? ~pulse_cnt : 1'b0;
      rvalid    <= (state == RD_SAMPLE) ? port_onehot(owner_q) : 3'b000;
      if (grant_fire) owner_q <= win_idx;
    end
  end

  // SRAM address/write data captured at grant; read data captured at the sample edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      sram_adr  <= '0;
      sram_dq_o <= '0;
      rdata     <= '0;
    end else begin
      if (grant_fire) begin
        sram_adr <= addr_sel;
        if (we_sel) sram_dq_o <= wdata_sel;
      end
      if (state == RD_SAMPLE) rdata <= sram_dq_i;
    end
  end

  assign owner = busy ? owner_q : 2'd3;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed cases followed by random traffic, checked
// by a transaction-level scoreboard and a behavioural SRAM.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [2:0]        req = '0;
  logic [2:0]        we  = '0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic [2:0]        gnt, rvalid, wdone;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] sram_adr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i = '0;
  logic              sram_oe_n, sram_we_n;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .wdone(wdone), .rdata(rdata),
    .busy(busy), .owner(owner), .sram_adr(sram_adr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #4 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int                port;
    bit                wr;
    bit [ADDR_W-1:0]   a;
    bit [DATA_W-1:0]   d;
    int                due;
  } exp_t;

  exp_t            exp_q[$];
  bit [DATA_W-1:0] sram_mem [bit [ADDR_W-1:0]];
  bit [DATA_W-1:0] ref_mem  [bit [ADDR_W-1:0]];
  int              free_cyc = 0;
  int              gnt_cyc  = -10;
  int              cur_port = 3;
  int              rr_ptr   = 0;
  logic [DATA_W-1:0] rdata_shadow = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Behavioural SRAM: drives data while OE is low, commits on the rising WE edge
  initial begin
    logic prev_we_n;
    prev_we_n = 1'b1;
    forever begin
      @(negedge CLK);
      if (!sram_oe_n)
        sram_dq_i = sram_mem.exists(sram_adr) ? sram_mem[sram_adr] : '0;
      else
        sram_dq_i = 16'hDEAD;
      if (!prev_we_n && sram_we_n && sram_dq_oe) sram_mem[sram_adr] = sram_dq_o;
      prev_we_n = sram_we_n;
    end
  end

  function automatic int pick(input logic [2:0] r);
`ifdef SRAM_ARB_RR_EN
    for (int i = 0; i < 3; i++) if (r[(rr_ptr + i) % 3]) return (rr_ptr + i) % 3;
`else
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  function automatic logic [ADDR_W-1:0] port_addr(input int p);
    return (p == 0) ? addr0 : (p == 1) ? addr1 : addr2;
  endfunction

  function automatic logic [DATA_W-1:0] port_data(input int p);
    return (p == 0) ? wdata0 : (p == 1) ? wdata1 : wdata2;
  endfunction

  task automatic set_port(input int i, input bit w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    we[i] = w;
    case (i)
      0: begin addr0 = a; wdata0 = d; end
      1: begin addr1 = a; wdata1 = d; end
      default: begin addr2 = a; wdata2 = d; end
    endcase
  endtask

  task automatic reset_model();
    exp_q.delete();
    free_cyc     = cyc + 1;
    gnt_cyc      = -10;
    cur_port     = 3;
    rr_ptr       = 0;
    rdata_shadow = '0;
  endtask

  // Issue side: called just after inputs are driven for the current cycle
  task automatic observe(output int p);
    exp_t e;
    int   len;
    bit   bsy;
    p = -1;
    #1;
    if (RST) return;
    bsy = (cyc > gnt_cyc) && (cyc < free_cyc);
    chk("busy", 32'(busy), 32'(bsy));
    chk("owner", 32'(owner), bsy ? 32'(cur_port) : 32'd3);
    if (cyc >= free_cyc) p = pick(req);
    chk("gnt", 32'(gnt), (p >= 0) ? (32'd1 << p) : 32'd0);
    if (p >= 0) begin
      e.port = p;
      e.wr   = we[p];
      e.a    = port_addr(p);
      if (e.wr) begin
        e.d   = port_data(p);
        len   = 4;
        e.due = cyc + 4;
      end else begin
        e.d   = ref_mem.exists(e.a) ? ref_mem[e.a] : '0;
        len   = 3 + RD_WAIT;
        e.due = cyc + len + 1;
      end
      exp_q.push_back(e);
      gnt_cyc  = cyc;
      free_cyc = cyc + len + 1;
      cur_port = p;
      rr_ptr   = (p + 1) % 3;
    end
  endtask

  // Completion monitor and per-cycle bus rules
  initial begin
    exp_t e;
    int   we_run;
    we_run = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (RST) begin
        we_run = 0;
      end else begin
        chk("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
        chk("dqoe_oe_overlap", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
        chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("rvalid_onehot", 32'($onehot0(rvalid)), 32'd1);
        chk("wdone_onehot", 32'($onehot0(wdone)), 32'd1);
        if (!busy) begin
          chk("idle_pins", {29'd0, sram_oe_n, sram_we_n, sram_dq_oe}, 32'd6);
        end
        if (!sram_we_n) begin
          we_run++;
        end else begin
          if (we_run != 0) chk("we_pulse_len", 32'(we_run), 32'd2);
          we_run = 0;
        end
        if (rvalid != 3'b000 || wdone != 3'b000) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: rvalid=%b wdone=%b, expected none (cycle %0d)",
                     rvalid, wdone, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.due));
            chk("rvalid_vec", 32'(rvalid), e.wr ? 32'd0 : (32'd1 << e.port));
            chk("wdone_vec", 32'(wdone), e.wr ? (32'd1 << e.port) : 32'd0);
            if (e.wr) ref_mem[e.a] = e.d;
            else      rdata_shadow = e.d;
          end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_done: port %0d due cycle %0d, nothing seen by %0d",
                   e.port, e.due, cyc);
        end
        chk("rdata", 32'(rdata), 32'(rdata_shadow));
      end
    end
  end

  // Stimulus
  initial begin
    int   p;
    int   n;
    int   last_p;
    int   order[6];
    logic rec_oe[7], rec_we[7], rec_dqoe[7];
    logic [2:0] rec_rv[7], rec_wd[7];
    logic [DATA_W-1:0] rec_rd[7], rec_dq[7];
    bit   g1_seen;

    // Reset values
    RST = 1'b1;
    reset_model();
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wdone", 32'(wdone), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_strobes", {29'd0, sram_oe_n, sram_we_n, sram_dq_oe}, 32'd6);
    chk("rst_adr", 32'(sram_adr), 32'd0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset_model();
    @(negedge CLK);
    RST = 1'b0;
    observe(p);

    // Port-2 read of a preloaded word
    sram_mem[20'h00010] = 16'h1234;
    ref_mem[20'h00010]  = 16'h1234;
    @(negedge CLK);
    set_port(2, 1'b0, 20'h00010, 16'h0);
    req = 3'b100;
    observe(p);
    chk("rd_gnt", 32'(gnt), 32'd4);
    for (int k = 1; k < 7; k++) begin
      @(negedge CLK);
      req = 3'b000;
      observe(p);
      rec_oe[k] = sram_oe_n;
      rec_rv[k] = rvalid;
      rec_rd[k] = rdata;
    end
    for (int k = 1; k < 7; k++) begin
      chk($sformatf("rd_oe_n_t%0d", k), 32'(rec_oe[k]),
          32'(!(k >= 2 && k <= 3 + RD_WAIT)));
      chk($sformatf("rd_rvalid_t%0d", k), 32'(rec_rv[k]),
          (k == 4 + RD_WAIT) ? 32'd4 : 32'd0);
    end
    chk("rd_rdata", 32'(rec_rd[4 + RD_WAIT]), 32'h1234);
    chk("rd_adr_held", 32'(sram_adr), 32'h00010);

    // Port-0 write
    @(negedge CLK);
    set_port(0, 1'b1, 20'h40000, 16'h00AA);
    req = 3'b001;
    observe(p);
    rec_we[0] = sram_we_n; rec_dqoe[0] = sram_dq_oe; rec_wd[0] = wdone; rec_dq[0] = sram_dq_o;
    for (int k = 1; k < 7; k++) begin
      @(negedge CLK);
      req = 3'b000;
      observe(p);
      rec_we[k] = sram_we_n; rec_dqoe[k] = sram_dq_oe; rec_wd[k] = wdone; rec_dq[k] = sram_dq_o;
    end
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wr_we_n_t%0d", k), 32'(rec_we[k]), 32'(!(k == 2 || k == 3)));
      chk($sformatf("wr_dq_oe_t%0d", k), 32'(rec_dqoe[k]), 32'(k >= 1 && k <= 4));
      chk($sformatf("wr_wdone_t%0d", k), 32'(rec_wd[k]), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("wr_dq_o", 32'(rec_dq[1]), 32'h00AA);
    chk("wr_mem", sram_mem.exists(20'h40000) ? 32'(sram_mem[20'h40000]) : 32'hFFFF_FFFF,
        32'h00AA);

    // Port-1 request raised and dropped while port 0 owns the bus
    g1_seen = 1'b0;
    @(negedge CLK);
    set_port(0, 1'b1, 20'h00003, 16'h3333);
    req = 3'b001;
    observe(p);
    for (int k = 1; k < 9; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        set_port(1, 1'b1, 20'h00005, 16'h5555);
        req = 3'b010;
      end else begin
        req = 3'b000;
      end
      observe(p);
      if (gnt[1]) g1_seen = 1'b1;
    end
    chk("drop_no_gnt1", 32'(g1_seen), 32'd0);
    chk("drop_no_write", 32'(sram_mem.exists(20'h00005)), 32'd0);

    // Reset during the first write-pulse cycle
    @(negedge CLK);
    set_port(0, 1'b1, 20'h00123, 16'h5A5A);
    req = 3'b001;
    observe(p);
    @(negedge CLK);
    req = 3'b000;
    observe(p);
    @(negedge CLK);
    chk("rstw_pulse_low", 32'(sram_we_n), 32'd0);
    RST = 1'b1;
    reset_model();
    @(negedge CLK);
    #1;
    chk("rstw_we_n", 32'(sram_we_n), 32'd1);
    chk("rstw_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_wdone", 32'(wdone), 32'd0);
    chk("rstw_owner", 32'(owner), 32'd3);
    chk("rstw_adr", 32'(sram_adr), 32'd0);
    chk("rstw_rdata", 32'(rdata), 32'd0);
    RST = 1'b0;
    reset_model();
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      observe(p);
    end
    chk("rstw_no_write", 32'(sram_mem.exists(20'h00123)), 32'd0);

    // All three ports requesting continuously
    for (int i = 0; i < 3; i++) set_port(i, 1'b0, 20'(i + 8), 16'h0);
    n = 0;
    for (int k = 0; k < 100 && n < 6; k++) begin
      @(negedge CLK);
      req = 3'b111;
      observe(p);
      if (gnt != 3'b000) begin
        order[n] = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : (gnt == 3'b100) ? 2 : 9;
        n++;
      end
    end
    chk("arb_grant_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) begin
`ifdef SRAM_ARB_RR_EN
      chk($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(i % 3));
`else
      chk($sformatf("arb_order_%0d", i), 32'(order[i]), 32'd0);
`endif
    end

    // Random traffic
    @(negedge CLK);
    req = 3'b000;
    observe(last_p);
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          if (i == last_p) begin
            if ($urandom_range(0, 1) == 1)
              set_port(i, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)),
                       16'($urandom));
            else
              req[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_port(i, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 16'($urandom));
          req[i] = 1'b1;
        end
      end
      observe(last_p);
    end

    // Drain and final memory comparison
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      req = 3'b000;
      observe(p);
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    foreach (ref_mem[a]) begin
      chk($sformatf("mem_%0h", a), sram_mem.exists(a) ? 32'(sram_mem[a]) : 32'hFFFF_FFFF,
          32'(ref_mem[a]));
    end
    chk("mem_word_count", 32'(sram_mem.num()), 32'(ref_mem.num()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning SRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning SRAM data width.
REQ-003 The block SHALL have parameter RD_WAIT, default 1, range 0-7, meaning extra OE-low cycles before read sample.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, exposed as the ports listed in REQ-005 and REQ-006.
REQ-005 CLK  in  1  sole clock, 125 MHz system clock.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 req[2:0]  in  3  access request per port: 0 = capture writer, 1 = match engine, 2 = USB readout.
REQ-008 we[2:0]  in  3  per port, 1 = write, 0 = read.
REQ-009 addr0/addr1/addr2  in  ADDR_W each  per-port word address.
REQ-010 wdata0/wdata1/wdata2  in  DATA_W each  per-port write data.
REQ-011 gnt[2:0]  out  3  one-cycle pulse when that port's request is accepted.
REQ-012 rvalid[2:0]  out  3  one-cycle pulse when rdata holds that port's read result.
REQ-013 wdone[2:0]  out  3  one-cycle pulse when that port's write completes.
REQ-014 rdata  out  DATA_W  registered read data, shared by all ports.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.
REQ-016 owner  out  2  port owning the current access; 3 when idle.
REQ-017 sram_adr  out  ADDR_W  SRAM address.
REQ-018 sram_dq_o  out  DATA_W  write data, to be tristated at top level.
REQ-019 sram_dq_oe  out  1  drive enable for sram_dq_o.
REQ-020 sram_dq_i  in  DATA_W  SRAM data input.
REQ-021 sram_oe_n  out  1  SRAM output enable, active low.
REQ-022 sram_we_n  out  1  SRAM write enable, active low.

Function
REQ-023 The block SHALL implement states IDLE, RD_ADDR, RD_OE, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-024 The block SHALL arbitrate only in IDLE, granting in the same cycle any request is high, and SHALL sample addr, we and wdata of the winner on that edge.
REQ-025 Without ARB_RR_EN, the block SHALL use fixed priority: port 0 > port 1 > port 2.
REQ-026 A requester SHALL hold req until gnt; req dropped before gnt SHALL cause no SRAM access.
REQ-027 A requester MAY keep req high after gnt; that request SHALL be treated as a new request.
REQ-028 Read sequence:
- RD_ADDR: 1 cycle, sram_adr valid, sram_oe_n=1.
- RD_OE: 1+RD_WAIT cycles, sram_oe_n=0.
- RD_SAMPLE: 1 cycle, sram_oe_n=0, rdata captured from sram_dq_i at the end of the cycle.
- Then IDLE, with rvalid[owner]=1 in that IDLE cycle.
REQ-029 Read latency SHALL be 4+RD_WAIT cycles from gnt to rvalid.
REQ-030 Write sequence:
- WR_SETUP: 1 cycle, sram_adr and sram_dq_o valid, sram_dq_oe=1, sram_we_n=1.
- WR_PULSE: 2 cycles, sram_we_n=0.
- WR_HOLD: 1 cycle, sram_we_n=1, sram_dq_oe=1, wdone[owner]=1.
- Then IDLE.
REQ-031 Back-to-back accesses SHALL be permitted, with the grant issued in the IDLE cycle that follows the previous sequence.
REQ-032 In IDLE the block SHALL drive sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, and SHALL hold sram_adr at its last value.
REQ-033 sram_oe_n=0 and sram_we_n=0 SHALL never be asserted in the same cycle.
REQ-034 sram_dq_oe=1 and sram_oe_n=0 SHALL never be asserted in the same cycle.
REQ-035 rdata SHALL hold its value until the next RD_SAMPLE.
REQ-036 Only one of gnt, rvalid and wdone bits SHALL be high per vector per cycle.

Reset
REQ-037 RST SHALL force, on the next edge: state IDLE, gnt=rvalid=wdone=0, busy=0, owner=3, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_adr=0, sram_dq_o=0, rdata=0, round-robin pointer=0.
REQ-038 RST mid-access SHALL abandon the access, producing no rvalid or wdone for it.
REQ-039 RST asserted during WR_PULSE SHALL deassert sram_we_n on the very next edge.

Configuration
REQ-040 Macro SRAM_ARB_RR_EN, when defined, SHALL make arbitration round-robin.
- The pointer SHALL advance to grantee+1 mod 3 after each grant.
- The search SHALL start at the pointer.
- No port with req held SHALL wait more than 2 accesses.
REQ-041 When SRAM_ARB_RR_EN is undefined, the block SHALL use fixed priority per REQ-025 and SHALL contain no pointer register.

Verification
REQ-042 Port-2 read, addr=0x00010, RD_WAIT=1, SRAM model returns 0x1234 -> gnt[2] at T, sram_oe_n low T+2..T+4, rvalid[2] at T+5 with rdata=0x1234.
REQ-043 Port-0 write, addr=0x40000, wdata=0x00AA -> sram_we_n low exactly 2 cycles, sram_dq_oe high 4 cycles, wdone[0] at T+4, model holds 0x00AA.
REQ-044 req=3'b111 held 6 grants -> fixed-priority build: all grants to port 0; SRAM_ARB_RR_EN build: grant order 0,1,2,0,1,2.
REQ-045 RST pulsed in the first WR_PULSE cycle -> sram_we_n=1 on the next edge, no wdone, busy=0, model not written.
REQ-046 Port-1 req raised then dropped in the same cycle that port 0 holds the bus -> no gnt[1], no access.
REQ-047 Random traffic for 10k cycles -> assertions of REQ-033, REQ-034 and REQ-036 never fire, and every gnt is matched by exactly one rvalid or wdone.
